// File: rtl/rule_scheduler.sv
// rule_scheduler: runs rounds of LFSR-ordered rules, each rule index
// applied once per round, and owns the network state register.
// Ports:
//   clk, rst        clock, async active-high reset
//   start, stop     run pulse / abort level (stop seen at capture)
//   seed            LFSR seed (0 -> ACE1)
//   init_state      network state loaded at run start
//   max_rounds      rounds to run
//   next_state      datapath result for the held rule
//   current_state   state register to the datapath
//   rule            held rule index, all-ones when idle
//   busy, done      run status
//   round_count     completed rounds
//   rule_strobe     one-cycle pulse after each capture
module rule_scheduler #(
   parameter int RULES       = 61,
   parameter int NUM_RULES   = 38,
   parameter int LOG_RULES   = 6,
   parameter int HOLD_CYCLES = 2,
   parameter int RND_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [15:0]          seed,
   input  logic [RULES-1:0]     init_state,
   input  logic [RND_W-1:0]     max_rounds,
   input  logic [RULES-1:0]     next_state,
   output logic [RULES-1:0]     current_state,
   output logic [LOG_RULES-1:0] rule,
   output logic                 busy,
   output logic                 done,
   output logic [RND_W-1:0]     round_count,
   output logic                 rule_strobe
);
   localparam int HW = $clog2(HOLD_CYCLES);
   localparam logic [LOG_RULES-1:0] IDLE_RULE = '1;
   localparam logic [LOG_RULES-1:0] NR        = LOG_RULES'(NUM_RULES);
   localparam logic [LOG_RULES-1:0] LAST_P    = LOG_RULES'(NUM_RULES - 1);
   localparam logic [LOG_RULES-1:0] P_ONE     = LOG_RULES'(1);
   localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0]        H_ONE     = HW'(1);
   localparam logic [RND_W-1:0]     R_ONE     = RND_W'(1);
   localparam logic [15:0]          LFSR_INIT = 16'hACE1;
   localparam logic [15:0]          LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SEED, S_PROBE, S_HOLD, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [RULES-1:0]     cur_q, cur_d;
   logic [LOG_RULES-1:0] rule_q, rule_d;
   logic [LOG_RULES-1:0] p_q, p_d;
   logic [RND_W-1:0]     round_q, round_d;
   logic [RND_W-1:0]     maxr_q, maxr_d;
   logic [NUM_RULES-1:0] visited_q, visited_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic                 strobe_q, strobe_d;

   logic [NUM_RULES-1:0] sel;
   logic [LOG_RULES-1:0] lfsr_lo;
   logic [15:0]          lfsr_nxt;

   assign sel      = {{(NUM_RULES-1){1'b0}}, 1'b1} << p_q;
   assign lfsr_lo  = lfsr_q[LOG_RULES-1:0];
   // Right-shift Galois form of x^16+x^14+x^13+x^11+1
   assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      rule_d    = rule_q;
      p_d       = p_q;
      round_d   = round_q;
      maxr_d    = maxr_q;
      visited_d = visited_q;
      lfsr_d    = lfsr_q;
      hold_d    = hold_q;
      strobe_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            cur_d     = init_state;
            lfsr_d    = (seed == 16'h0) ? LFSR_INIT : seed;
            round_d   = '0;
            visited_d = '0;
            maxr_d    = max_rounds;
            state_d   = (max_rounds == '0) ? S_DONE : S_SEED;
         end
         S_SEED: begin
            // 2**LOG_RULES <= 2*NUM_RULES, so one subtract folds into range
            p_d     = (lfsr_lo >= NR) ? lfsr_lo - NR : lfsr_lo;
            lfsr_d  = lfsr_nxt;
            state_d = S_PROBE;
         end
         S_PROBE: begin
            // visited is cleared on round completion, so an unvisited
            // index always exists and the walk ends within NUM_RULES
            if ((visited_q & sel) == '0) begin
               rule_d  = p_q;
               hold_d  = '0;
               state_d = S_HOLD;
            end else begin
               p_d = (p_q == LAST_P) ? '0 : p_q + P_ONE;
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               cur_d    = next_state;
               strobe_d = 1'b1;
               rule_d   = IDLE_RULE;
               if (&(visited_q | sel)) begin
                  visited_d = '0;
                  if (round_q != '1) round_d = round_q + R_ONE;
                  state_d = ((round_q + R_ONE) == maxr_q || stop)
                            ? S_DONE : S_SEED;
               end else begin
                  visited_d = visited_q | sel;
                  state_d   = stop ? S_DONE : S_SEED;
               end
            end else begin
               hold_d = hold_q + H_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cur_q     <= '0;
         rule_q    <= IDLE_RULE;
         p_q       <= '0;
         round_q   <= '0;
         maxr_q    <= '0;
         visited_q <= '0;
         lfsr_q    <= LFSR_INIT;
         hold_q    <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         rule_q    <= rule_d;
         p_q       <= p_d;
         round_q   <= round_d;
         maxr_q    <= maxr_d;
         visited_q <= visited_d;
         lfsr_q    <= lfsr_d;
         hold_q    <= hold_d;
         strobe_q  <= strobe_d;
      end
   end

   assign current_state = cur_q;
   assign rule          = rule_q;
   assign round_count   = round_q;
   assign rule_strobe   = strobe_q;
   assign done          = (state_q == S_DONE);
   assign busy          = (state_q == S_LOAD) || (state_q == S_SEED) ||
                          (state_q == S_PROBE) || (state_q == S_HOLD);

endmodule

// File: tb/tb_rule_scheduler.sv
// tb_rule_scheduler: scoreboard bench for rule_scheduler.
// Datapath stand-in: next_state = current_state + rule + 1.
module tb_rule_scheduler;
   localparam int RULES       = 61;
   localparam int NUM_RULES   = 38;
   localparam int LOG_RULES   = 6;
   localparam int HOLD_CYCLES = 2;
   localparam int RND_W       = 16;
   localparam logic [LOG_RULES-1:0] IDLE_RULE = '1;

   logic                 clk = 1'b0;
   logic                 rst, start, stop;
   logic [15:0]          seed;
   logic [RULES-1:0]     init_state, next_state, current_state;
   logic [RND_W-1:0]     max_rounds, round_count;
   logic [LOG_RULES-1:0] rule;
   logic                 busy, done, rule_strobe;

   int n_cmp = 0;
   int n_bad = 0;
   int               exp_rule_q[$];
   logic [RULES-1:0] exp_state_q[$];
   int               obs_q[$];
   int               seq_a[$];

   always #5 clk = ~clk;

   assign next_state = current_state + RULES'(rule) + RULES'(1);

   rule_scheduler #(
      .RULES(RULES), .NUM_RULES(NUM_RULES), .LOG_RULES(LOG_RULES),
      .HOLD_CYCLES(HOLD_CYCLES), .RND_W(RND_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .seed(seed), .init_state(init_state), .max_rounds(max_rounds),
      .next_state(next_state), .current_state(current_state),
      .rule(rule), .busy(busy), .done(done),
      .round_count(round_count), .rule_strobe(rule_strobe)
   );

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
   endfunction

   task automatic gen_expected(input logic [15:0] sd, input int rounds,
                               input int limit, input logic [RULES-1:0] init);
      logic [15:0]          lf;
      logic [NUM_RULES-1:0] vis;
      logic [RULES-1:0]     st;
      logic [LOG_RULES-1:0] p;
      int n;
      lf = (sd == 16'h0) ? 16'hACE1 : sd;
      vis = '0;
      st = init;
      n = 0;
      for (int r = 0; r < rounds; r++) begin
         for (int k = 0; k < NUM_RULES; k++) begin
            p = lf[LOG_RULES-1:0];
            if (p >= LOG_RULES'(NUM_RULES)) p = p - LOG_RULES'(NUM_RULES);
            lf = lfsr_step(lf);
            while (vis[p])
               p = (p == LOG_RULES'(NUM_RULES-1)) ? '0 : p + LOG_RULES'(1);
            vis[p] = 1'b1;
            st = st + RULES'(p) + RULES'(1);
            if (n < limit) begin
               exp_rule_q.push_back(int'(p));
               exp_state_q.push_back(st);
            end
            n++;
         end
         vis = '0;
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      n_cmp++;
      if (current_state !== '0) begin
         n_bad++; $display("FAIL %s state got %h want 0", nm, current_state);
      end
      n_cmp++;
      if (rule !== IDLE_RULE) begin
         n_bad++; $display("FAIL %s rule got %0d want %0d", nm, rule, IDLE_RULE);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL %s busy got %b want 0", nm, busy);
      end
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++; $display("FAIL %s done got %b want 0", nm, done);
      end
      n_cmp++;
      if (round_count !== '0) begin
         n_bad++; $display("FAIL %s rounds got %0d want 0", nm, round_count);
      end
      n_cmp++;
      if (rule_strobe !== 1'b0) begin
         n_bad++; $display("FAIL %s strobe got %b want 0", nm, rule_strobe);
      end
   endtask

   // Runs one job and scores every capture against the model.
   // stop_at >= 0: raise stop while the (stop_at+1)-th rule is held.
   task automatic run_check(input string nm, input logic [15:0] sd,
                            input int rounds, input int stop_at,
                            input bit poke, input logic [RULES-1:0] init);
      int limit, caps, held, budget, er, exp_rc;
      logic [RULES-1:0]     es;
      logic [LOG_RULES-1:0] last;
      logic [NUM_RULES-1:0] mask;
      bit finished, poked;
      exp_rule_q.delete();
      exp_state_q.delete();
      obs_q.delete();
      limit = (stop_at >= 0) ? stop_at + 1 : rounds * NUM_RULES;
      gen_expected(sd, rounds, limit, init);
      @(negedge clk);
      seed = sd; max_rounds = RND_W'(rounds); init_state = init; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      caps = 0; held = 0; last = IDLE_RULE; finished = 1'b0; poked = 1'b0;
      budget = rounds * NUM_RULES * (NUM_RULES + 6) + 50;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         if (rule_strobe) begin
            n_cmp++;
            if (exp_rule_q.size() == 0) begin
               n_bad++;
               $display("FAIL %s extra capture rule %0d got, none wanted", nm, last);
            end else begin
               er = exp_rule_q.pop_front();
               es = exp_state_q.pop_front();
               if (int'(last) !== er) begin
                  n_bad++;
                  $display("FAIL %s cap%0d rule got %0d want %0d", nm, caps, last, er);
               end
               n_cmp++;
               if (current_state !== es) begin
                  n_bad++;
                  $display("FAIL %s cap%0d state got %h want %h", nm, caps,
                           current_state, es);
               end
            end
            n_cmp++;
            if (held !== HOLD_CYCLES) begin
               n_bad++;
               $display("FAIL %s cap%0d hold got %0d want %0d", nm, caps, held,
                        HOLD_CYCLES);
            end
            obs_q.push_back(int'(last));
            caps++;
            held = 0;
         end
         if (rule != IDLE_RULE) begin
            held++;
            last = rule;
         end
         if (stop_at >= 0 && caps == stop_at && rule != IDLE_RULE) stop = 1'b1;
         if (poke && caps == 5 && !poked) begin
            start = 1'b1; poked = 1'b1;
         end else start = 1'b0;
         if (done) begin
            finished = 1'b1;
            break;
         end
      end
      stop = 1'b0;
      start = 1'b0;
      n_cmp++;
      if (!finished) begin
         n_bad++; $display("FAIL %s timeout done got 0 want 1", nm);
      end
      n_cmp++;
      if (exp_rule_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s missing captures got %0d want %0d", nm, caps, limit);
      end
      exp_rc = (stop_at >= 0) ? stop_at / NUM_RULES : rounds;
      n_cmp++;
      if (round_count !== RND_W'(exp_rc)) begin
         n_bad++;
         $display("FAIL %s round_count got %0d want %0d", nm, round_count, exp_rc);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL %s busy at end got %b want 0", nm, busy);
      end
      for (int g = 0; g < obs_q.size() / NUM_RULES; g++) begin
         mask = '0;
         for (int k = 0; k < NUM_RULES; k++)
            if (obs_q[g*NUM_RULES+k] < NUM_RULES) mask[obs_q[g*NUM_RULES+k]] = 1'b1;
         n_cmp++;
         if (mask !== '1) begin
            n_bad++;
            $display("FAIL %s round%0d permutation got %h want all ones", nm, g, mask);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      seed = '0; max_rounds = '0; init_state = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("after_reset");
   endtask

   task automatic test_zero_rounds();
      logic [RULES-1:0] iv;
      iv = RULES'(64'h0F1E_2D3C_4B5A_6978);
      @(negedge clk);
      seed = 16'h0077; max_rounds = '0; init_state = iv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_bad++; $display("FAIL zero_rounds load busy/done got %b%b want 10", busy, done);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++; $display("FAIL zero_rounds done got %b want 1", done);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL zero_rounds busy got %b want 0", busy);
      end
      n_cmp++;
      if (current_state !== iv) begin
         n_bad++; $display("FAIL zero_rounds state got %h want %h", current_state, iv);
      end
      n_cmp++;
      if (rule_strobe !== 1'b0 || rule !== IDLE_RULE) begin
         n_bad++;
         $display("FAIL zero_rounds strobe/rule got %b/%0d want 0/%0d",
                  rule_strobe, rule, IDLE_RULE);
      end
      n_cmp++;
      if (round_count !== '0) begin
         n_bad++; $display("FAIL zero_rounds rounds got %0d want 0", round_count);
      end
   endtask

   task automatic test_seed_equivalence();
      logic [RULES-1:0] iv;
      bit differs;
      iv = RULES'(64'h1357_9BDF_0246_8ACE);
      run_check("seed0", 16'h0000, 1, -1, 1'b0, iv);
      seq_a = obs_q;
      run_check("seedACE1", 16'hACE1, 1, -1, 1'b0, iv);
      n_cmp++;
      if (obs_q != seq_a) begin
         n_bad++;
         $display("FAIL seed0_vs_ACE1 sequences got differing want identical");
      end
      run_check("seed1234", 16'h1234, 2, -1, 1'b1, iv);
      differs = 1'b0;
      for (int k = 0; k < NUM_RULES; k++)
         if (k < obs_q.size() && k < seq_a.size() && obs_q[k] != seq_a[k])
            differs = 1'b1;
      n_cmp++;
      if (!differs) begin
         n_bad++;
         $display("FAIL seed1234_differs got identical want different sequence");
      end
   endtask

   task automatic test_stop();
      run_check("stop", 16'h5A5A, 3, NUM_RULES + 9, 1'b0, RULES'(64'hABCDEF));
   endtask

   task automatic test_reset_mid_run();
      int guard;
      @(negedge clk);
      seed = 16'h0BAD; max_rounds = RND_W'(5);
      init_state = RULES'(64'hFFFF_0000_FFFF); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (rule == IDLE_RULE && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (rule == IDLE_RULE) begin
         n_bad++; $display("FAIL rst_mid no hold reached got idle want rule");
      end
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      run_check("post_rst", 16'h2468, 1, -1, 1'b0, RULES'(64'h42));
   endtask

   initial begin
      test_reset();
      test_zero_rounds();
      test_seed_equivalence();
      test_stop();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
